// File: rtl/alarm_pkg.sv
// Shared encodings for the alarm set path and the VGA highlight decode.
package alarm_pkg;

  // Field-select codes seen by the VGA output stage
  localparam logic [1:0] ST_SEC  = 2'd0;
  localparam logic [1:0] ST_MIN  = 2'd1;
  localparam logic [1:0] ST_HOUR = 2'd2;
  localparam logic [1:0] ST_NONE = 2'd3;

  // Upper limits of the two-digit BCD fields
  localparam int unsigned MAX_MS = 59;
  localparam int unsigned MAX_H  = 23;

  typedef enum logic [2:0] {
    StRun,
    StEditSec,
    StEditMin,
    StEditHour,
    StRing
  } fsm_e;

  // Binary 0..99 to packed two-digit BCD {msb, lsb}
  function automatic logic [7:0] to_bcd(input int unsigned v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  // Field-select code presented for a given FSM state
  function automatic logic [1:0] field_sel(input fsm_e s);
    logic [1:0] sel;
    case (s)
      StEditSec:  sel = ST_SEC;
      StEditMin:  sel = ST_MIN;
      StEditHour: sel = ST_HOUR;
      default:    sel = ST_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/bcd2_updown.sv
// Two-digit BCD register with wrap-around increment/decrement and parallel load.
module bcd2_updown
  import alarm_pkg::*;
#(
  parameter int unsigned MAX     = 59,
  parameter int unsigned RST_VAL = 0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       inc,
  input  logic       dec,
  input  logic       load,
  input  logic [3:0] load_msb,
  input  logic [3:0] load_lsb,
  output logic [3:0] msb,
  output logic [3:0] lsb
);

  localparam logic [7:0] MaxBcd = to_bcd(MAX);
  localparam logic [7:0] RstBcd = to_bcd(RST_VAL);

  logic [3:0] msb_d, lsb_d, msb_q, lsb_q;

  // Next value: load first, then inc/dec; both together cancel
  always_comb begin
    msb_d = msb_q;
    lsb_d = lsb_q;
    if (load) begin
      msb_d = load_msb;
      lsb_d = load_lsb;
    end else if (inc && !dec) begin
      if ({msb_q, lsb_q} == MaxBcd) begin
        msb_d = 4'd0;
        lsb_d = 4'd0;
      end else if (lsb_q == 4'd9) begin
        msb_d = msb_q + 4'd1;
        lsb_d = 4'd0;
      end else begin
        lsb_d = lsb_q + 4'd1;
      end
    end else if (dec && !inc) begin
      if ({msb_q, lsb_q} == 8'h00) begin
        msb_d = MaxBcd[7:4];
        lsb_d = MaxBcd[3:0];
      end else if (lsb_q == 4'd0) begin
        msb_d = msb_q - 4'd1;
        lsb_d = 4'd9;
      end else begin
        lsb_d = lsb_q - 4'd1;
      end
    end
  end

  // Digit registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      msb_q <= RstBcd[7:4];
      lsb_q <= RstBcd[3:0];
    end else begin
      msb_q <= msb_d;
      lsb_q <= lsb_d;
    end
  end

  assign msb = msb_q;
  assign lsb = lsb_q;

endmodule

// File: rtl/alarm_set_ctrl.sv
// Alarm time registers, edit-mode FSM and timed ring with blinking highlight.
module alarm_set_ctrl
  import alarm_pkg::*;
#(
  parameter int unsigned RING_SECS = 30,
  parameter int unsigned RST_HOUR  = 6,
  parameter int unsigned RST_MIN   = 0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       tick_1hz,
  input  logic       alarm_en,
  input  logic [3:0] insecMSB,
  input  logic [3:0] insecLSB,
  input  logic [3:0] inminMSB,
  input  logic [3:0] inminLSB,
  input  logic [3:0] inhourMSB,
  input  logic [3:0] inhourLSB,
  output logic [3:0] alarmsecMSB,
  output logic [3:0] alarmsecLSB,
  output logic [3:0] alarmminMSB,
  output logic [3:0] alarmminLSB,
  output logic [3:0] alarmhourMSB,
  output logic [3:0] alarmhourLSB,
  output logic [1:0] state,
  output logic       settime,
  output logic       alarm_ring
);

  localparam logic [5:0] RingLast = 6'(RING_SECS);

  fsm_e       fsm_d, fsm_q;
  logic [5:0] cnt_d, cnt_q;
  logic       settime_d, settime_q;
  logic       ring_q;
  logic [1:0] state_q;
  logic       match, match_d;

  // mode has priority; up+down together cancels
  logic btn_any, step_up, step_dn;
  assign btn_any = btn_mode | btn_up | btn_down;
  assign step_up = btn_up & ~btn_down & ~btn_mode;
  assign step_dn = btn_down & ~btn_up & ~btn_mode;

  logic sec_sel, min_sel, hour_sel;
  assign sec_sel  = (fsm_q == StEditSec);
  assign min_sel  = (fsm_q == StEditMin);
  assign hour_sel = (fsm_q == StEditHour);

  bcd2_updown #(.MAX(MAX_MS), .RST_VAL(0)) u_sec (
    .clk      (clk),
    .reset_n  (reset_n),
    .inc      (step_up & sec_sel),
    .dec      (step_dn & sec_sel),
    .load     (1'b0),
    .load_msb (4'd0),
    .load_lsb (4'd0),
    .msb      (alarmsecMSB),
    .lsb      (alarmsecLSB)
  );

  bcd2_updown #(.MAX(MAX_MS), .RST_VAL(RST_MIN)) u_min (
    .clk      (clk),
    .reset_n  (reset_n),
    .inc      (step_up & min_sel),
    .dec      (step_dn & min_sel),
    .load     (1'b0),
    .load_msb (4'd0),
    .load_lsb (4'd0),
    .msb      (alarmminMSB),
    .lsb      (alarmminLSB)
  );

  bcd2_updown #(.MAX(MAX_H), .RST_VAL(RST_HOUR)) u_hour (
    .clk      (clk),
    .reset_n  (reset_n),
    .inc      (step_up & hour_sel),
    .dec      (step_dn & hour_sel),
    .load     (1'b0),
    .load_msb (4'd0),
    .load_lsb (4'd0),
    .msb      (alarmhourMSB),
    .lsb      (alarmhourLSB)
  );

  assign match = ({insecMSB, insecLSB, inminMSB, inminLSB, inhourMSB, inhourLSB} ==
                  {alarmsecMSB, alarmsecLSB, alarmminMSB, alarmminLSB,
                   alarmhourMSB, alarmhourLSB});

  // Next-state, ring counter and highlight blink
  always_comb begin
    fsm_d     = fsm_q;
    cnt_d     = cnt_q;
    settime_d = 1'b0;
    case (fsm_q)
      StRun: begin
        // Rising edge of match only, so an alarm equal to the time on leaving edit stays quiet
        if (match && !match_d && alarm_en) begin
          fsm_d     = StRing;
          cnt_d     = 6'd0;
          settime_d = 1'b1;
        end else if (btn_mode) begin
          fsm_d = StEditSec;
        end
      end
      StEditSec:  if (btn_mode) fsm_d = StEditMin;
      StEditMin:  if (btn_mode) fsm_d = StEditHour;
      StEditHour: if (btn_mode) fsm_d = StRun;
      StRing: begin
        // Any button or alarm_en low dismisses and wins over a same-cycle tick
        if (btn_any || !alarm_en) begin
          fsm_d = StRun;
        end else begin
          settime_d = settime_q;
          if (tick_1hz) begin
            cnt_d     = cnt_q + 6'd1;
            settime_d = ~settime_q;
            if (cnt_q + 6'd1 == RingLast) begin
              fsm_d     = StRun;
              settime_d = 1'b0;
            end
          end
        end
      end
      default: fsm_d = StRun;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fsm_q     <= StRun;
      cnt_q     <= 6'd0;
      settime_q <= 1'b0;
      ring_q    <= 1'b0;
      state_q   <= ST_NONE;
      match_d   <= 1'b0;
    end else begin
      fsm_q     <= fsm_d;
      cnt_q     <= cnt_d;
      settime_q <= settime_d;
      ring_q    <= (fsm_d == StRing);
      state_q   <= field_sel(fsm_d);
      match_d   <= match;
    end
  end

  assign state      = state_q;
  assign settime    = settime_q;
  assign alarm_ring = ring_q;

endmodule

// File: tb/tb_alarm_set_ctrl.sv
// Directed bench for alarm_set_ctrl: edit vectors table plus ring sequences.
module tb_alarm_set_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        btn_mode, btn_up, btn_down, tick_1hz, alarm_en;
  logic [23:0] time_bcd;  // {hM, hL, mM, mL, sM, sL}
  logic [3:0]  a_sm, a_sl, a_mm, a_ml, a_hm, a_hl;
  logic [1:0]  state;
  logic        settime, alarm_ring;
  logic [23:0] alarm_bcd;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  assign alarm_bcd = {a_hm, a_hl, a_mm, a_ml, a_sm, a_sl};

  alarm_set_ctrl #(.RING_SECS(30), .RST_HOUR(6), .RST_MIN(0)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .btn_mode     (btn_mode),
    .btn_up       (btn_up),
    .btn_down     (btn_down),
    .tick_1hz     (tick_1hz),
    .alarm_en     (alarm_en),
    .insecMSB     (time_bcd[7:4]),
    .insecLSB     (time_bcd[3:0]),
    .inminMSB     (time_bcd[15:12]),
    .inminLSB     (time_bcd[11:8]),
    .inhourMSB    (time_bcd[23:20]),
    .inhourLSB    (time_bcd[19:16]),
    .alarmsecMSB  (a_sm),
    .alarmsecLSB  (a_sl),
    .alarmminMSB  (a_mm),
    .alarmminLSB  (a_ml),
    .alarmhourMSB (a_hm),
    .alarmhourLSB (a_hl),
    .state        (state),
    .settime      (settime),
    .alarm_ring   (alarm_ring)
  );

  typedef struct {
    logic        mode;
    logic        up;
    logic        dn;
    logic [23:0] exp_alarm;
    logic [1:0]  exp_state;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic m, input logic u, input logic d,
                     input logic [23:0] a, input logic [1:0] s);
    vec_t v;
    v.mode = m; v.up = u; v.dn = d; v.exp_alarm = a; v.exp_state = s;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Sample point: 1 time unit after the active edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Move the time off the alarm and back so match rises again
  task automatic rering();
    time_bcd = 24'h060001;
    step();
    time_bcd = 24'h060000;
    step();
    chk("rering", {31'd0, alarm_ring}, 32'd1);
  endtask

  initial begin
    reset_n  = 1'b0;
    btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
    tick_1hz = 1'b0; alarm_en = 1'b0;
    time_bcd = 24'h123456;

    // Edit sequence; time held far from the alarm and alarm_en low
    add(0, 0, 0, 24'h060000, 2'd3);
    add(1, 0, 0, 24'h060000, 2'd0);
    add(0, 0, 1, 24'h060059, 2'd0);
    add(0, 1, 0, 24'h060000, 2'd0);
    add(0, 1, 0, 24'h060001, 2'd0);
    add(0, 1, 1, 24'h060001, 2'd0);
    add(1, 1, 0, 24'h060001, 2'd1);
    add(0, 0, 1, 24'h065901, 2'd1);
    add(0, 1, 0, 24'h060001, 2'd1);
    add(1, 0, 0, 24'h060001, 2'd2);
    add(0, 0, 1, 24'h050001, 2'd2);
    add(0, 0, 1, 24'h040001, 2'd2);
    add(0, 0, 1, 24'h030001, 2'd2);
    add(0, 0, 1, 24'h020001, 2'd2);
    add(0, 0, 1, 24'h010001, 2'd2);
    add(0, 0, 1, 24'h000001, 2'd2);
    add(0, 0, 1, 24'h230001, 2'd2);
    add(0, 1, 0, 24'h000001, 2'd2);
    add(0, 0, 1, 24'h230001, 2'd2);
    add(0, 0, 1, 24'h220001, 2'd2);
    add(0, 0, 1, 24'h210001, 2'd2);
    add(0, 0, 1, 24'h200001, 2'd2);
    add(0, 0, 1, 24'h190001, 2'd2);
    add(0, 1, 0, 24'h200001, 2'd2);
    add(1, 0, 0, 24'h200001, 2'd3);
    add(0, 1, 0, 24'h200001, 2'd3);
    add(0, 0, 1, 24'h200001, 2'd3);

    #12 reset_n = 1'b1;
    chk("rst_alarm", {8'd0, alarm_bcd}, {8'd0, 24'h060000});
    chk("rst_state", {30'd0, state}, 32'd3);
    chk("rst_settime", {31'd0, settime}, 32'd0);
    chk("rst_ring", {31'd0, alarm_ring}, 32'd0);
    repeat (10) step();
    chk("idle_alarm", {8'd0, alarm_bcd}, {8'd0, 24'h060000});
    chk("idle_state", {30'd0, state}, 32'd3);

    foreach (vecs[i]) begin
      btn_mode = vecs[i].mode;
      btn_up   = vecs[i].up;
      btn_down = vecs[i].dn;
      step();
      btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
      chk($sformatf("vec%0d_alarm", i), {8'd0, alarm_bcd}, {8'd0, vecs[i].exp_alarm});
      chk($sformatf("vec%0d_state", i), {30'd0, state}, {30'd0, vecs[i].exp_state});
      chk($sformatf("vec%0d_settime", i), {31'd0, settime}, 32'd0);
      chk($sformatf("vec%0d_ring", i), {31'd0, alarm_ring}, 32'd0);
    end

    // Restore the default alarm
    #2 reset_n = 1'b0;
    #2 reset_n = 1'b1;
    step();
    chk("rst2_alarm", {8'd0, alarm_bcd}, {8'd0, 24'h060000});

    // Full-length ring
    time_bcd = 24'h055959;
    alarm_en = 1'b1;
    step(); step();
    chk("pre_match_ring", {31'd0, alarm_ring}, 32'd0);
    time_bcd = 24'h060000;
    #1 chk("ring_before_edge", {31'd0, alarm_ring}, 32'd0);
    step();
    chk("ring_rise", {31'd0, alarm_ring}, 32'd1);
    chk("ring_settime", {31'd0, settime}, 32'd1);
    chk("ring_state", {30'd0, state}, 32'd3);
    for (int i = 1; i <= 30; i++) begin
      tick_1hz = 1'b1;
      step();
      tick_1hz = 1'b0;
      if (i < 30) begin
        chk($sformatf("tick%0d_ring", i), {31'd0, alarm_ring}, 32'd1);
        chk($sformatf("tick%0d_settime", i), {31'd0, settime}, (i % 2 == 0) ? 32'd1 : 32'd0);
        step();
      end else begin
        chk("ring_end", {31'd0, alarm_ring}, 32'd0);
        chk("ring_end_settime", {31'd0, settime}, 32'd0);
        chk("ring_end_state", {30'd0, state}, 32'd3);
      end
    end
    repeat (5) step();
    chk("hold_no_rering", {31'd0, alarm_ring}, 32'd0);

    // Button dismiss beats a same-cycle tick and is consumed
    rering();
    btn_mode = 1'b1; tick_1hz = 1'b1;
    step();
    btn_mode = 1'b0; tick_1hz = 1'b0;
    chk("dismiss_ring", {31'd0, alarm_ring}, 32'd0);
    chk("dismiss_settime", {31'd0, settime}, 32'd0);
    chk("dismiss_state", {30'd0, state}, 32'd3);
    repeat (3) step();
    chk("dismiss_state_hold", {30'd0, state}, 32'd3);
    chk("dismiss_no_rering", {31'd0, alarm_ring}, 32'd0);

    // alarm_en falling dismisses; disabled alarm never rings
    rering();
    alarm_en = 1'b0;
    step();
    chk("en_drop_ring", {31'd0, alarm_ring}, 32'd0);
    time_bcd = 24'h060001;
    step();
    time_bcd = 24'h060000;
    step(); step();
    chk("en_low_no_ring", {31'd0, alarm_ring}, 32'd0);

    // Asynchronous reset mid-ring
    alarm_en = 1'b1;
    rering();
    #2 reset_n = 1'b0;
    #1;
    chk("async_ring", {31'd0, alarm_ring}, 32'd0);
    chk("async_settime", {31'd0, settime}, 32'd0);
    chk("async_state", {30'd0, state}, 32'd3);
    alarm_en = 1'b0;
    #2 reset_n = 1'b1;
    step(); step();
    chk("post_rst_no_ring", {31'd0, alarm_ring}, 32'd0);
    chk("post_rst_alarm", {8'd0, alarm_bcd}, {8'd0, 24'h060000});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
